// File: rtl/logic_unit_pkg.sv
// -----------------------------------------------------------------------------
// logic_unit_pkg
// Shared definitions for the registered logic unit and its serial shifter:
//   - default operand / result widths (the result width is shared with the
//     arithmetic units so every unit feeds the same result mux)
//   - operation code enum (3-bit op field)
//   - controller state enum
// -----------------------------------------------------------------------------
package logic_unit_pkg;

  localparam int LU_WIDTH     = 32;
  localparam int LU_OUT_WIDTH = 67;

  typedef enum logic [2:0] {
    OP_AND  = 3'b000,
    OP_OR   = 3'b001,
    OP_XOR  = 3'b010,
    OP_NAND = 3'b011,
    OP_NOR  = 3'b100,
    OP_XNOR = 3'b101,
    OP_SHL  = 3'b110,
    OP_SHR  = 3'b111
  } lu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } lu_state_e;

  function automatic logic is_shift_op(input lu_op_e op);
    return (op == OP_SHL) || (op == OP_SHR);
  endfunction

endpackage

// File: rtl/logic_serial_shifter.sv
// -----------------------------------------------------------------------------
// logic_serial_shifter
// Work register plus down-counter for one-bit-per-clock logical shifts.
// Ports:
//   clk       system clock, rising edge
//   rst_b     asynchronous active-low reset (clears work, count, direction)
//   i_load    load i_data / i_amount / direction from i_op
//   i_op      operation; only SHL vs. SHR matters here
//   i_data    shift source
//   i_amount  number of single-bit steps to perform (must be > 0 when loaded)
//   i_step    advance one bit position and decrement the count
//   o_next    work value after one more step (zero fill)
//   o_last    the step about to be taken is the final one (count == 1)
// -----------------------------------------------------------------------------
module logic_serial_shifter
  import logic_unit_pkg::*;
#(
  parameter int WIDTH = LU_WIDTH,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_b,
  input  logic             i_load,
  input  lu_op_e           i_op,
  input  logic [WIDTH-1:0] i_data,
  input  logic [SHW-1:0]   i_amount,
  input  logic             i_step,
  output logic [WIDTH-1:0] o_next,
  output logic             o_last
);

  logic [WIDTH-1:0] r_work;
  logic [SHW-1:0]   r_cnt;
  logic             r_left;

  // The controller captures o_next on the last step, so the final shifted
  // value never has to sit in r_work for an extra cycle.
  assign o_next = r_left ? (r_work << 1) : (r_work >> 1);
  assign o_last = (r_cnt == SHW'(1));

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      r_work <= '0;
      r_cnt  <= '0;
      r_left <= 1'b0;
    end else if (i_load) begin
      r_work <= i_data;
      r_cnt  <= i_amount;
      r_left <= (i_op == OP_SHL);
    end else if (i_step) begin
      r_work <= o_next;
      r_cnt  <= r_cnt - SHW'(1);
    end
  end

endmodule

// File: rtl/logic_unit_seq.sv
// -----------------------------------------------------------------------------
// logic_unit_seq
// Registered logic unit: AND/OR/XOR/NAND/NOR/XNOR in one cycle, logical
// SHL/SHR serially at one bit per clock, with a start/busy/done handshake.
// The result is zero-extended to OUT_WIDTH for the shared result mux.
// Ports:
//   clk     system clock, rising edge
//   rst_b   asynchronous active-low reset; abandons any operation in flight
//   start   request, sampled only while idle
//   op      operation code (see lu_op_e)
//   a       operand A / shift source
//   b       operand B; for shifts b[SHW-1:0] is the shift amount
//   busy    high whenever the unit is not idle
//   done    one-cycle pulse, result valid from this cycle
//   result  registered result, bits [OUT_WIDTH-1:WIDTH] always zero
// Optional build macro LOGIC_UNIT_SEQ_FLAGS_EN adds:
//   zero    registered (result[WIDTH-1:0] == 0), resets to 1
//   parity  registered XOR-reduce of result[WIDTH-1:0], resets to 0
// -----------------------------------------------------------------------------
module logic_unit_seq
  import logic_unit_pkg::*;
#(
  parameter int WIDTH     = LU_WIDTH,
  parameter int OUT_WIDTH = LU_OUT_WIDTH,
  parameter int SHW       = $clog2(WIDTH)
) (
  input  logic                 clk,
  input  logic                 rst_b,
  input  logic                 start,
  input  logic [2:0]           op,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 busy,
  output logic                 done,
  output logic [OUT_WIDTH-1:0] result
`ifdef LOGIC_UNIT_SEQ_FLAGS_EN
  ,
  output logic                 zero,
  output logic                 parity
`endif
);

  lu_state_e        r_state;
  lu_state_e        w_state_next;
  lu_op_e           w_op;
  logic [SHW-1:0]   w_k;
  logic [WIDTH-1:0] w_bitwise;
  logic [WIDTH-1:0] w_shift_next;
  logic [WIDTH-1:0] w_res_val;
  logic             w_res_load;
  logic             w_load;
  logic             w_step;
  logic             w_last;
  logic [WIDTH-1:0] r_result;

  assign w_op = lu_op_e'(op);
  assign w_k  = b[SHW-1:0];

  // Single-cycle path. Shift codes fall through to A, which is exactly the
  // answer for a zero shift amount.
  always_comb begin
    w_bitwise = a;
    case (w_op)
      OP_AND:  w_bitwise = a & b;
      OP_OR:   w_bitwise = a | b;
      OP_XOR:  w_bitwise = a ^ b;
      OP_NAND: w_bitwise = ~(a & b);
      OP_NOR:  w_bitwise = ~(a | b);
      OP_XNOR: w_bitwise = ~(a ^ b);
      default: w_bitwise = a;
    endcase
  end

  logic_serial_shifter #(
    .WIDTH (WIDTH),
    .SHW   (SHW)
  ) u_shifter (
    .clk      (clk),
    .rst_b    (rst_b),
    .i_load   (w_load),
    .i_op     (w_op),
    .i_data   (a),
    .i_amount (w_k),
    .i_step   (w_step),
    .o_next   (w_shift_next),
    .o_last   (w_last)
  );

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) r_state <= ST_IDLE;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_load       = 1'b0;
    w_step       = 1'b0;
    w_res_load   = 1'b0;
    w_res_val    = w_bitwise;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          if (is_shift_op(w_op) && (w_k != '0)) begin
            w_load       = 1'b1;
            w_state_next = ST_SHIFT;
          end else begin
            w_res_load   = 1'b1;
            w_res_val    = w_bitwise;
            w_state_next = ST_DONE;
          end
        end
      end
      ST_SHIFT: begin
        w_step = 1'b1;
        if (w_last) begin
          w_res_load   = 1'b1;
          w_res_val    = w_shift_next;
          w_state_next = ST_DONE;
        end
      end
      ST_DONE: begin
        w_state_next = ST_IDLE;
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b)          r_result <= '0;
    else if (w_res_load) r_result <= w_res_val;
  end

  assign busy = (r_state != ST_IDLE);
  assign done = (r_state == ST_DONE);

  generate
    if (OUT_WIDTH > WIDTH) begin : g_zext
      assign result = {{(OUT_WIDTH - WIDTH){1'b0}}, r_result};
    end else begin : g_nozext
      assign result = r_result;
    end
  endgenerate

`ifdef LOGIC_UNIT_SEQ_FLAGS_EN
  logic r_zero;
  logic r_parity;

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      r_zero   <= 1'b1;
      r_parity <= 1'b0;
    end else if (w_res_load) begin
      r_zero   <= (w_res_val == '0);
      r_parity <= ^w_res_val;
    end
  end

  assign zero   = r_zero;
  assign parity = r_parity;
`endif

endmodule

// File: doc/logic_unit_seq.md
Name: logic_unit_seq

Overview:
- Parametrised, registered successor to the team's combinational AND/OR/XOR blocks.
- Adds NAND/NOR/XNOR and serial logical shifts, with a start/busy/done handshake.
- Result is zero-extended to the shared datapath result width (67 bits by default), so it plugs into the same result mux as the arithmetic units.
- Shifts execute one bit per clock, like the team's other sequential arithmetic units.

Parameters:
- WIDTH, 32: operand width in bits.
- OUT_WIDTH, 67: result bus width; must be >= WIDTH; bits [OUT_WIDTH-1:WIDTH] are always 0.
- SHW, $clog2(WIDTH): shift-amount width (derived; do not override).

Ports:
- clk  input  1  system clock, rising edge.
- rst_b  input  1  asynchronous active-low reset.
- start  input  1  request; sampled only in IDLE.
- op  input  3  operation code: 000 AND, 001 OR, 010 XOR, 011 NAND, 100 NOR, 101 XNOR, 110 SHL, 111 SHR.
- a  input  WIDTH  operand A; the shift source for SHL/SHR.
- b  input  WIDTH  operand B; for shifts, b[SHW-1:0] is the shift amount k and the upper bits are ignored.
- busy  output  1  high whenever state != IDLE.
- done  output  1  one-cycle pulse; result is valid from this cycle.
- result  output  OUT_WIDTH  registered result, zero-extended.

Behaviour:
- Reset (async, rst_b=0): state=IDLE; result=0; done=0; busy=0; work register and counter cleared. Applies at any time, including mid-shift; the operation in progress is abandoned with no done pulse.
- FSM states: IDLE, SHIFT, DONE.
- IDLE + start=1, bitwise op (000-101), or shift with k=0:
  - On that edge, result <= zero-extended op(a,b); for k=0 the value is a.
  - Next state is DONE. Latency = 1 cycle (done high in the cycle after start).
- IDLE + start=1, shift with k>0:
  - On that edge, load work<=a and cnt<=k; next state is SHIFT.
- SHIFT, each cycle:
  - SHL: work <= work<<1. SHR: work <= work>>1. Logical shifts, zero fill.
  - cnt <= cnt-1.
  - When cnt==1: result <= zero-extended final shifted value; next state is DONE.
  - Total latency = k+1 cycles from the start cycle to done.
- DONE: done=1 for exactly one cycle, then return to IDLE. result holds until the next completed operation.
- start is ignored while busy=1 (SHIFT or DONE); no queuing. A new start is accepted in the cycle after done.
- op, a and b are sampled only on the accepted start edge; later changes have no effect on the operation in progress.
- result never changes during SHIFT; the previous result stays visible.
- Max shift is WIDTH-1 (k=31 by default) with latency WIDTH cycles; no wrap-around.

Optional Feature:
- Macro: LOGIC_UNIT_SEQ_FLAGS_EN.
- Defined: adds output zero (1 bit) and output parity (1 bit, XOR-reduce of result[WIDTH-1:0]).
  - Both are registered and updated on the same edge as result.
  - Both reset to zero=1, parity=0.
- Undefined: both ports and their logic are absent; all other behaviour is identical.

Decomposition:
- Package logic_unit_pkg:
  - op enum (8 codes above);
  - state enum (IDLE/SHIFT/DONE);
  - default WIDTH/OUT_WIDTH localparams, shared with the arithmetic units' result width.
- Sub-module: logic_serial_shifter. Holds the work register and down-counter, and signals last-step. The top keeps the FSM, the bitwise mux and the result register.

Test Plan:
1. Bitwise ops, a=32'h0000FFFF, b=32'hFFFF0000:
   - AND -> result=0; OR -> 67'h0_FFFFFFFF; XOR -> 67'h0_FFFFFFFF.
   - Each shows done exactly 1 cycle after start, with result[66:32]=0.
2. NAND, a=32'hF0F0F0F0, b=32'hFFFFFFFF -> 67'h0_0F0F0F0F. XNOR on the same operands -> 67'h0_F0F0F0F0.
3. SHL, a=32'h1, b=5:
   - busy high for 6 cycles; done 6 cycles after start; result=67'h20.
   - result unchanged from the previous value during SHIFT.
4. SHR, a=32'h80000000, b=31 -> done after 32 cycles, result=1. start pulses with other ops during busy are ignored and the result is unaffected.
5. SHL with b=0 (or b=32'h20, low bits 0) -> latency 1, result=a.
6. rst_b pulsed low mid-SHR (cycle 10 of 32):
   - Immediately: result=0, busy=0, done=0.
   - No done pulse is ever produced for the abandoned operation.
   - A next start of AND completes normally.
